// File: rtl/conv3_weight_fetch_ctrl_if.sv
// Signal bundle between the conv3 weight-fetch controller, the host loader,
// the conv3 engine stream and BRAM port A.
interface conv3_weight_fetch_ctrl_if #(
  parameter int AW = 12
);
  logic          host_wr_req;
  logic [AW-1:0] host_wr_addr;
  logic [31:0]   host_wr_data;
  logic [3:0]    host_wr_be;
  logic          host_wr_ack;

  logic          fetch_start;
  logic [AW-1:0] fetch_base;
  logic [AW:0]   fetch_len;
  logic          fetch_busy;
  logic          fetch_done;
  logic          fetch_err;

  logic [31:0]   w_data;
  logic          w_valid;
  logic          w_ready;
  logic          w_last;

  logic [31:0]   bram_addr;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout;

  modport slave (
    input  host_wr_req, host_wr_addr, host_wr_data, host_wr_be,
    output host_wr_ack,
    input  fetch_start, fetch_base, fetch_len,
    output fetch_busy, fetch_done, fetch_err,
    output w_data, w_valid, w_last,
    input  w_ready,
    output bram_addr, bram_en, bram_we, bram_din,
    input  bram_dout
  );

  modport master (
    output host_wr_req, host_wr_addr, host_wr_data, host_wr_be,
    input  host_wr_ack,
    output fetch_start, fetch_base, fetch_len,
    input  fetch_busy, fetch_done, fetch_err,
    input  w_data, w_valid, w_last,
    output w_ready,
    input  bram_addr, bram_en, bram_we, bram_din,
    output bram_dout
  );
endinterface

// File: rtl/conv3_weight_fetch_ctrl.sv
// Port-A arbiter for the conv3 weight BRAM: host writes vs. engine burst reads,
// with a credit-checked output FIFO absorbing the BRAM read latency.
//   state    | meaning
//   ST_IDLE  | no burst; host writes granted, fetch_start evaluated
//   ST_BURST | issuing reads, round-robin against host writes
//   ST_FLUSH | all reads issued, draining FIFO until the last word pops
module conv3_weight_fetch_ctrl #(
  parameter int AW         = 12,
  parameter int DEPTH      = 4096,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic                      clk,
  input logic                      rst,
  conv3_weight_fetch_ctrl_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]   FIFO_DEPTH_W = (CW+1)'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST     = PW'(FIFO_DEPTH - 1);
  localparam logic [AW+1:0] DEPTH_W      = (AW+2)'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_FLUSH} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [AW:0]     len_q, len_d, rd_issued_q, rd_issued_d, pop_cnt_q, pop_cnt_d;
  logic            rr_host_q, rr_host_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d, outst_q, outst_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [31:0]     fifo_mem_q [FIFO_DEPTH];
  logic [31:0]     fifo_mem_d [FIFO_DEPTH];
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
  logic [31:0]     bram_addr_q, bram_addr_d, bram_din_q, bram_din_d;
  logic            bram_en_q, bram_en_d;
  logic [3:0]      bram_we_q, bram_we_d;
  logic            ack_q, ack_d, done_q, done_d, err_q, err_d;

  logic            host_gnt, rd_gnt, rd_elig, push, pop, w_valid, last_word;
  logic [AW+1:0]   fetch_end;
  logic [AW-1:0]   rd_idx;
  logic [CW:0]     credit_sum;

  assign fetch_end  = {2'b00, bus.fetch_base} + {1'b0, bus.fetch_len};
  assign rd_idx     = base_q + rd_issued_q[AW-1:0];
  // Reads in flight count against FIFO space so returning data always has a slot.
  assign credit_sum = {1'b0, fifo_cnt_q} + {1'b0, outst_q};
  assign push       = rd_pipe_q[RD_LAT-1];
  assign w_valid    = (fifo_cnt_q != '0);
  assign pop        = w_valid & bus.w_ready;
  assign last_word  = w_valid && ((pop_cnt_q + (AW+1)'(1)) == len_q);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    rd_issued_d = rd_issued_q;
    rr_host_d   = rr_host_q;
    pop_cnt_d   = pop ? pop_cnt_q + (AW+1)'(1) : pop_cnt_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    host_gnt    = 1'b0;
    rd_gnt      = 1'b0;
    rd_elig     = (rd_issued_q < len_q) && (credit_sum < FIFO_DEPTH_W);
    unique case (state_q)
      ST_IDLE: begin
        host_gnt = bus.host_wr_req;
        if (bus.fetch_start) begin
          if (bus.fetch_len == '0) begin
            done_d = 1'b1;
          end else if (fetch_end > DEPTH_W) begin
            err_d = 1'b1;
          end else begin
            base_d      = bus.fetch_base;
            len_d       = bus.fetch_len;
            rd_issued_d = '0;
            pop_cnt_d   = '0;
            state_d     = ST_BURST;
          end
        end
      end
      ST_BURST: begin
        if (rd_elig && bus.host_wr_req) begin
          host_gnt  = rr_host_q;
          rd_gnt    = ~rr_host_q;
          rr_host_d = ~rr_host_q;
        end else begin
          rd_gnt   = rd_elig;
          host_gnt = bus.host_wr_req;
        end
        if (rd_gnt) begin
          rd_issued_d = rd_issued_q + (AW+1)'(1);
          if (rd_issued_d == len_q) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        host_gnt = bus.host_wr_req;
        if (pop && last_word) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ack_d       = host_gnt;
    bram_en_d   = host_gnt | rd_gnt;
    bram_we_d   = host_gnt ? bus.host_wr_be : 4'h0;
    bram_din_d  = host_gnt ? bus.host_wr_data : 32'h0;
    bram_addr_d = 32'h0;
    if (host_gnt)    bram_addr_d = {{(30-AW){1'b0}}, bus.host_wr_addr, 2'b00};
    else if (rd_gnt) bram_addr_d = {{(30-AW){1'b0}}, rd_idx, 2'b00};

    rd_pipe_d    = '0;
    rd_pipe_d[0] = bram_en_q && (bram_we_q == 4'h0);
    for (int i = 1; i < RD_LAT; i++) rd_pipe_d[i] = rd_pipe_q[i-1];

    fifo_mem_d = fifo_mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    if (push) begin
      fifo_mem_d[wr_ptr_q] = bus.bram_dout;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PW'(1);
    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);
    outst_d    = outst_q + CW'(rd_gnt) - CW'(push);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      rd_issued_q <= '0;
      pop_cnt_q   <= '0;
      rr_host_q   <= 1'b1;
      fifo_cnt_q  <= '0;
      outst_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      rd_pipe_q   <= '0;
      bram_addr_q <= '0;
      bram_din_q  <= '0;
      bram_en_q   <= 1'b0;
      bram_we_q   <= '0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      rd_issued_q <= rd_issued_d;
      pop_cnt_q   <= pop_cnt_d;
      rr_host_q   <= rr_host_d;
      fifo_cnt_q  <= fifo_cnt_d;
      outst_q     <= outst_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fifo_mem_q  <= fifo_mem_d;
      rd_pipe_q   <= rd_pipe_d;
      bram_addr_q <= bram_addr_d;
      bram_din_q  <= bram_din_d;
      bram_en_q   <= bram_en_d;
      bram_we_q   <= bram_we_d;
      ack_q       <= ack_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign bus.host_wr_ack = ack_q;
  assign bus.fetch_busy  = (state_q != ST_IDLE);
  assign bus.fetch_done  = done_q;
  assign bus.fetch_err   = err_q;
  assign bus.w_data      = fifo_mem_q[rd_ptr_q];
  assign bus.w_valid     = w_valid;
  assign bus.w_last      = last_word;
  assign bus.bram_addr   = bram_addr_q;
  assign bus.bram_en     = bram_en_q;
  assign bus.bram_we     = bram_we_q;
  assign bus.bram_din    = bram_din_q;
endmodule

// File: tb/tb_conv3_weight_fetch_ctrl.sv
// Scoreboard bench for conv3_weight_fetch_ctrl: a BRAM model on port A, a
// reference memory updated by host writes, and a stream monitor.
module tb_conv3_weight_fetch_ctrl;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3_weight_fetch_ctrl_if #(.AW(AW)) bus ();

  conv3_weight_fetch_ctrl #(.AW(AW), .DEPTH(4096), .RD_LAT(1), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem     [4096];
  logic [31:0] ref_mem [4096];
  logic [32:0] sb[$];
  logic [32:0] sb_item;
  bit          ops[$];
  bit          rec_ops = 1'b0;
  int          rd_seen = 0;
  int          pop_seen = 0;
  logic [31:0] last_rd_addr = '0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  int          fv, dc, w, dn, rd0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // BRAM port A model, one-cycle read latency
  always @(posedge clk) begin
    if (bus.bram_en) begin
      if (bus.bram_we != 4'h0) begin
        for (int b = 0; b < 4; b++)
          if (bus.bram_we[b]) mem[bus.bram_addr[13:2]][b*8 +: 8] = bus.bram_din[b*8 +: 8];
      end else begin
        bus.bram_dout <= mem[bus.bram_addr[13:2]];
      end
    end
  end

  // Stream monitor: pops expected words whenever a transfer occurs
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      rd_seen    = 0;
      pop_seen   = 0;
    end else begin
      if (prev_stall) begin
        chk("w_hold_valid", bus.w_valid, 1);
        chk("w_hold_data", bus.w_data, prev_data);
      end
      prev_stall = bus.w_valid && !bus.w_ready;
      prev_data  = bus.w_data;
      if (bus.bram_en && bus.bram_we == 4'h0) begin
        rd_seen++;
        last_rd_addr = bus.bram_addr;
      end
      if (rec_ops && bus.bram_en) ops.push_back(bus.bram_we != 4'h0);
      if (bus.w_valid && bus.w_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w_unexpected: got word 0x%0h last %0d, expected none", bus.w_data, bus.w_last);
        end else begin
          sb_item = sb.pop_front();
          chk("w_data", bus.w_data, sb_item[31:0]);
          chk("w_last", bus.w_last, sb_item[32]);
        end
        pop_seen++;
      end
      if (bus.fetch_busy) chk("credit_bound", (rd_seen - pop_seen) <= 4, 1);
    end
  end

  task automatic check_all_zero(input string p);
    chk({p, "_ctl"}, {bus.host_wr_ack, bus.fetch_busy, bus.fetch_done, bus.fetch_err,
                      bus.w_valid, bus.w_last, bus.bram_en, bus.bram_we}, 0);
    chk({p, "_w_data"}, bus.w_data, 0);
    chk({p, "_bram_addr"}, bus.bram_addr, 0);
    chk({p, "_bram_din"}, bus.bram_din, 0);
  endtask

  task automatic host_write(input int a, input logic [31:0] d, input logic [3:0] be);
    bus.host_wr_req  = 1'b1;
    bus.host_wr_addr = AW'(a);
    bus.host_wr_data = d;
    bus.host_wr_be   = be;
    @(posedge clk); #1;
    chk("host_ack", bus.host_wr_ack, 1);
    chk("host_bram_en", bus.bram_en, 1);
    chk("host_bram_we", bus.bram_we, be);
    chk("host_bram_addr", bus.bram_addr, 32'(a) << 2);
    chk("host_bram_din", bus.bram_din, d);
    bus.host_wr_req = 1'b0;
    for (int b = 0; b < 4; b++) if (be[b]) ref_mem[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  task automatic host_stream(input int n);
    int wt;
    for (int k = 0; k < n; k++) begin
      bus.host_wr_req  = 1'b1;
      bus.host_wr_addr = AW'(300 + k);
      bus.host_wr_data = 32'hC0DE_0000 + 32'(k);
      bus.host_wr_be   = 4'hF;
      wt = 0;
      do begin
        @(posedge clk); #1;
        wt++;
      end while (!bus.host_wr_ack && wt < 6);
      chk("contention_ack_wait", wt <= 2, 1);
      ref_mem[300 + k] = 32'hC0DE_0000 + 32'(k);
    end
    bus.host_wr_req = 1'b0;
  endtask

  task automatic run_burst(input int base, input int len, input bit bp, input bit inject,
                           input bit push_exp, output int first_v, output int done_cyc);
    int cyc, errs;
    if (push_exp)
      for (int i = 0; i < len; i++) sb.push_back({(i == len - 1), ref_mem[base + i]});
    bus.fetch_start = 1'b1;
    bus.fetch_base  = AW'(base);
    bus.fetch_len   = (AW+1)'(len);
    @(posedge clk); #1;
    bus.fetch_start = 1'b0;
    cyc = 0; first_v = -1; done_cyc = -1; errs = 0;
    while (done_cyc < 0 && cyc < 400) begin
      if (bp) bus.w_ready = (cyc % 3 == 0);
      if (inject && cyc == 4) begin
        bus.fetch_start = 1'b1;
        bus.fetch_base  = AW'(4090);
        bus.fetch_len   = (AW+1)'(7);
      end else begin
        bus.fetch_start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
      if (bus.w_valid && first_v < 0) first_v = cyc;
      if (bus.fetch_err) errs++;
      if (bus.fetch_done) begin
        done_cyc = cyc;
        chk("busy_at_done", bus.fetch_busy, 0);
      end
    end
    bus.fetch_start = 1'b0;
    bus.w_ready = 1'b1;
    chk("done_seen", done_cyc >= 0, 1);
    chk("sb_drained", sb.size(), 0);
    chk("err_during_burst", errs, 0);
    if (done_cyc >= 0) begin
      @(posedge clk); #1;
      chk("done_single_pulse", bus.fetch_done, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'h5A00_0000 | 32'(i);
      ref_mem[i] = 32'h5A00_0000 | 32'(i);
    end
    bus.host_wr_req = 1'b0; bus.host_wr_addr = '0; bus.host_wr_data = '0; bus.host_wr_be = '0;
    bus.fetch_start = 1'b0; bus.fetch_base = '0;   bus.fetch_len = '0;
    bus.w_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    // host writes incl. a partial byte-enable overwrite
    host_write(0, 32'hDEADBEEF, 4'hF);
    host_write(5, 32'h12345678, 4'hF);
    host_write(5, 32'h000000AA, 4'h1);
    sb.push_back({1'b1, 32'h123456AA});
    run_burst(5, 1, 0, 0, 0, fv, dc);
    chk("single_first_valid", fv, 3);
    chk("single_done_lat", dc, 4);

    for (int i = 0; i < 16; i++) host_write(i, 32'(i), 4'hF);

    // full rate
    run_burst(0, 16, 0, 0, 1, fv, dc);
    chk("full_first_valid", fv, 3);
    chk("full_done_lat", dc, 19);

    // backpressure 1,0,0 pattern
    run_burst(0, 16, 1, 0, 1, fv, dc);

    // contention with continuous host writes
    ops.delete();
    rec_ops = 1'b1;
    fork
      run_burst(0, 8, 0, 0, 1, fv, dc);
      begin
        @(posedge clk); #1;
        host_stream(10);
      end
    join
    rec_ops = 1'b0;
    chk("contention_op_count", ops.size() >= 16, 1);
    for (int i = 1; i < 16 && i < ops.size(); i++) chk("contention_alternate", ops[i] != ops[i-1], 1);
    run_burst(300, 10, 0, 0, 1, fv, dc);

    // len == 0
    rd0 = rd_seen;
    bus.fetch_start = 1'b1; bus.fetch_base = AW'(10); bus.fetch_len = '0;
    @(posedge clk); #1;
    bus.fetch_start = 1'b0;
    chk("len0_done", {bus.fetch_done, bus.fetch_err, bus.fetch_busy}, 3'b100);
    repeat (4) @(posedge clk);
    #1;
    chk("len0_no_reads", rd_seen - rd0, 0);
    chk("len0_quiet", {bus.fetch_done, bus.w_valid}, 0);

    // out of range: 4090 + 7 > 4096
    rd0 = rd_seen;
    bus.fetch_start = 1'b1; bus.fetch_base = AW'(4090); bus.fetch_len = (AW+1)'(7);
    @(posedge clk); #1;
    bus.fetch_start = 1'b0;
    chk("range_err", {bus.fetch_done, bus.fetch_err, bus.fetch_busy}, 3'b010);
    repeat (4) @(posedge clk);
    #1;
    chk("range_no_reads", rd_seen - rd0, 0);
    chk("range_err_pulse", bus.fetch_err, 0);

    // exactly at the top: 4089 + 7 == 4096
    run_burst(4089, 7, 0, 0, 1, fv, dc);
    chk("top_last_addr", last_rd_addr, 32'h3FFC);

    // fetch_start while busy is ignored
    run_burst(0, 8, 0, 1, 1, fv, dc);

    // reset after 3 words popped
    for (int i = 0; i < 3; i++) sb.push_back({1'b0, ref_mem[i]});
    bus.fetch_start = 1'b1; bus.fetch_base = '0; bus.fetch_len = (AW+1)'(16);
    @(posedge clk); #1;
    bus.fetch_start = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    chk("rst_mid_three_popped", sb.size(), 0);
    rst = 1'b1;
    bus.w_ready = 1'b0;
    @(posedge clk); #1;
    check_all_zero("rst_mid");
    rst = 1'b0;
    bus.w_ready = 1'b1;
    dn = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.fetch_done || bus.w_valid || bus.fetch_busy) dn++;
    end
    chk("rst_mid_quiet", dn, 0);
    run_burst(0, 4, 0, 0, 1, fv, dc);
    chk("post_rst_first_valid", fv, 3);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
